// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone classic-cycle RAM responder with byte lanes, fixed latency
// and error responses for out-of-range or misaligned accesses.
module wb_ram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [31:0] SIZE_BYTES = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [AW-1:0]  idx_q;
  logic           we_q;
  logic [3:0]     sel_q;
  logic [31:0]    wdat_q;
  logic           err_q;
  logic [31:0]    dat_q;
  logic           ack_q;
  logic           berr_q;
  logic [31:0]    mem_q [DEPTH];

  logic [31:0]    offset;
  logic           req;
  logic           req_err;
  logic           enter_resp;
  logic [AW-1:0]  cur_idx;
  logic           cur_we;
  logic [3:0]     cur_sel;
  logic [31:0]    cur_dat;
  logic           cur_err;
  logic           mem_we;

  // Addresses below the base wrap to huge offsets and fall out of range.
  assign offset  = wb_adr_i - BASE_ADDR;
  assign req     = wb_cyc_i & wb_stb_i;
  assign req_err = (offset >= SIZE_BYTES) | (wb_adr_i[1:0] != 2'b00);

  // With zero wait states RESP is entered straight from IDLE, so the live bus
  // fields are used; otherwise the fields latched at the request are used.
  always_comb begin
    enter_resp = 1'b0;
    cur_idx    = idx_q;
    cur_we     = we_q;
    cur_sel    = sel_q;
    cur_dat    = wdat_q;
    cur_err    = err_q;
    case (state_q)
      ST_IDLE: begin
        enter_resp = req && (WAIT_CYCLES == 0);
        cur_idx    = offset[AW+1:2];
        cur_we     = wb_we_i;
        cur_sel    = wb_sel_i;
        cur_dat    = wb_dat_i;
        cur_err    = req_err;
      end
      ST_WAIT: enter_resp = wb_cyc_i && (cnt_q == 4'd1);
      default: enter_resp = 1'b0;
    endcase
  end

  assign mem_we = rstn_i & enter_resp & cur_we & ~cur_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_sel[k]) mem_q[cur_idx][8*k +: 8] <= cur_dat[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'd0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      ack_q  <= enter_resp & ~cur_err;
      berr_q <= enter_resp & cur_err;
      if (enter_resp) begin
        if (cur_err)     dat_q <= 32'd0;
        else if (!cur_we) dat_q <= mem_q[cur_idx];
      end
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            idx_q   <= offset[AW+1:2];
            we_q    <= wb_we_i;
            sel_q   <= wb_sel_i;
            wdat_q  <= wb_dat_i;
            err_q   <= req_err;
            cnt_q   <= WAIT_LOAD;
            state_q <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (!wb_cyc_i)           state_q <= ST_IDLE;
          else if (cnt_q == 4'd1)  state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = berr_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - directed vector bench for wb_ram_slave over three parameterisations.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        rstn [3];
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [31:0] adr  [3];
  logic [31:0] wdat [3];
  logic [3:0]  sel  [3];
  logic [31:0] rd_w [3];
  logic [2:0]  ack_w;
  logic [2:0]  err_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // A: basic/byte lanes; B: offset base, errors, abort, reset; C: zero wait, small depth.
  wb_ram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rstn_i(rstn[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_sel_i(sel[0]),
    .wb_dat_o(rd_w[0]), .wb_ack_o(ack_w[0]), .wb_err_o(err_w[0]));

  wb_ram_slave #(.DEPTH(1024), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .rstn_i(rstn[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_sel_i(sel[1]),
    .wb_dat_o(rd_w[1]), .wb_ack_o(ack_w[1]), .wb_err_o(err_w[1]));

  wb_ram_slave #(.DEPTH(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) u_c (
    .clk(clk), .rstn_i(rstn[2]), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
    .wb_adr_i(adr[2]), .wb_dat_i(wdat[2]), .wb_sel_i(sel[2]),
    .wb_dat_o(rd_w[2]), .wb_ack_o(ack_w[2]), .wb_err_o(err_w[2]));

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dt,
                         input logic [3:0] s, output logic got_ack, output logic got_err,
                         output logic [31:0] rdat, output int lat, output logic quiet);
    got_ack = 1'b0;
    got_err = 1'b0;
    lat     = 0;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dt; sel[d] = s;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ack_w[d] || err_w[d]) begin
        got_ack = ack_w[d];
        got_err = err_w[d];
        lat     = k;
        break;
      end
    end
    rdat   = rd_w[d];
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
    quiet = !ack_w[d] && !err_w[d];
  endtask

  initial begin
    logic        ga, ge, q, seen;
    logic [31:0] rd;
    int          lat;

    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = 32'd0; wdat[d] = 32'd0; sel[d] = 4'd0;
    end

    vt.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        3, "a_wr10"});
    vt.push_back('{0, 1'b0, 32'h10,  32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 3, "a_rd10"});
    vt.push_back('{0, 1'b1, 32'h20,  32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        3, "a_wr20"});
    vt.push_back('{0, 1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0,        3, "a_wr20_lanes"});
    vt.push_back('{0, 1'b0, 32'h20,  32'h0,        4'h1, 1'b1, 1'b0, 1'b1, 32'h11BB33DD, 3, "a_rd20"});
    vt.push_back('{0, 1'b1, 32'h24,  32'h01020304, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        3, "a_wr24"});
    vt.push_back('{0, 1'b1, 32'h24,  32'h55555555, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0,        3, "a_wr24_sel0"});
    vt.push_back('{0, 1'b0, 32'h24,  32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h01020304, 3, "a_rd24"});
    vt.push_back('{0, 1'b1, 32'hFFC, 32'hA5A50F0F, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,        3, "a_wr_last"});
    vt.push_back('{0, 1'b0, 32'hFFC, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hA5A50F0F, 3, "a_rd_last"});
    vt.push_back('{0, 1'b0, 32'h1000,32'h0,        4'hF, 1'b0, 1'b1, 1'b1, 32'h0,        3, "a_rd_past_end"});
    vt.push_back('{1, 1'b1, 32'h1000_0000, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,  4, "b_wr0"});
    vt.push_back('{1, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h12345678,  4, "b_rd0"});
    vt.push_back('{1, 1'b0, 32'h1000_1000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0,         4, "b_rd_high"});
    vt.push_back('{1, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0,         4, "b_rd_below"});
    vt.push_back('{1, 1'b0, 32'h1000_0001, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0,         4, "b_rd_misal"});
    vt.push_back('{1, 1'b1, 32'h1000_0002, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,  4, "b_wr_misal"});
    vt.push_back('{1, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h12345678,  4, "b_rd0_kept"});
    vt.push_back('{1, 1'b1, 32'h1000_0040, 32'h00001111, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,  4, "b_wr40"});
    vt.push_back('{1, 1'b1, 32'h1000_0080, 32'h00000042, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,  4, "b_wr80"});
    vt.push_back('{1, 1'b0, 32'h1000_0080, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h00000042,  4, "b_rd80"});
    vt.push_back('{2, 1'b1, 32'h3C, 32'h600DCAFE, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,         1, "c_wr_last"});
    vt.push_back('{2, 1'b0, 32'h3C, 32'h0, 4'hF, 1'b1, 1'b0, 1'b1, 32'h600DCAFE,         1, "c_rd_last"});
    vt.push_back('{2, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0,                1, "c_rd_past_end"});

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ack%0d", d), {31'd0, ack_w[d]}, 32'd0);
      chk($sformatf("reset_err%0d", d), {31'd0, err_w[d]}, 32'd0);
      chk($sformatf("reset_dat%0d", d), rd_w[d], 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rstn[d] = 1'b1;

    foreach (vt[i]) begin
      do_xfer(vt[i].d, vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, ga, ge, rd, lat, q);
      chk({vt[i].name, "_ack"}, {31'd0, ga}, {31'd0, vt[i].exp_ack});
      chk({vt[i].name, "_err"}, {31'd0, ge}, {31'd0, vt[i].exp_err});
      chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].exp_lat));
      chk({vt[i].name, "_one_cycle"}, {31'd0, q}, 32'd1);
      if (vt[i].chk_rd) chk({vt[i].name, "_rdat"}, rd, vt[i].exp_rd);
    end

    // Abort: cyc dropped in the first WAIT cycle must leave memory untouched.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h1000_0040;
    wdat[1] = 32'hCAFEF00D; sel[1] = 4'hF;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack_w[1] || err_w[1]) seen = 1'b1;
    end
    chk("abort_no_resp", {31'd0, seen}, 32'd0);
    do_xfer(1, 1'b0, 32'h1000_0040, 32'h0, 4'hF, ga, ge, rd, lat, q);
    chk("abort_rd_ack", {31'd0, ga}, 32'd1);
    chk("abort_rd_old", rd, 32'h00001111);

    // Back-to-back with zero wait: responses on alternate cycles only.
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h8;
    wdat[2] = 32'h0000_0777; sel[2] = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack_c%0d", c), {31'd0, ack_w[2]}, {31'd0, c[0]});
      chk($sformatf("b2b_err_c%0d", c), {31'd0, err_w[2]}, 32'd0);
    end
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    do_xfer(2, 1'b0, 32'h8, 32'h0, 4'hF, ga, ge, rd, lat, q);
    chk("b2b_rd", rd, 32'h0000_0777);

    // Reset during WAIT: outputs clear at once, uncommitted write is dropped.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h1000_0080;
    wdat[1] = 32'h0000_0099; sel[1] = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    rstn[1] = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, ack_w[1]}, 32'd0);
    chk("rst_mid_err", {31'd0, err_w[1]}, 32'd0);
    chk("rst_mid_dat", rd_w[1], 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn[1] = 1'b1;
    do_xfer(1, 1'b0, 32'h1000_0080, 32'h0, 4'hF, ga, ge, rd, lat, q);
    chk("rst_after_ack", {31'd0, ga}, 32'd1);
    chk("rst_after_lat", 32'(lat), 32'd4);
    chk("rst_after_rd", rd, 32'h00000042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
